spi_miso_tx_4mb: RTL and testbench
==================================

// Module: spi_miso_tx_4mb
// PURPOSE
//  Read-back/transmit side of the 4MB SPI register interface. The SPI receiver handles
//  address decode and write data. On a read frame, this block fetches the addressed
//  32-bit register through a read port and shifts it out MSB-first on MISO (SPI mode 0).
//  It runs fully in the clk_100m domain and oversamples SCLK/CS_N through synchronizers.
// PARAMETERS
//  DATA_W       32    shift word width
//  RD_LATENCY   1     clk_100m cycles from reg_rd_en to valid reg_rd_data (1..4)
//  SYNC_STAGES  2     synchronizer flops on spi_sclk and spi_cs_n (>=2)
//  IDLE_MISO    1'b0  MISO level when no data bit is being driven
// PORTS
//  clk_100m       in   1       system clock, 100 MHz
//  rst_n_syn      in   1       asynchronous active-low reset
//  spi_sclk       in   1       SPI clock from master, asynchronous
//  spi_cs_n       in   1       SPI chip select, active low, asynchronous
//  rd_start       in   1       1-cycle pulse from SPI receiver: read address decoded
//  rd_addr_in     in   16      register address qualified by rd_start
//  reg_rd_en      out  1       1-cycle read strobe to register block
//  reg_rd_addr    out  16      read address, held stable from reg_rd_en until LOAD
//  reg_rd_data    in   DATA_W  read data, sampled RD_LATENCY cycles after reg_rd_en
//  spi_miso       out  1       serial data to master
//  miso_oe        out  1       MISO output enable (pad tri-state control)
//  tx_busy        out  1       high in any state except IDLE
//  tx_done        out  1       1-cycle pulse: all DATA_W bits clocked out
//  tx_err         out  1       1-cycle pulse: underrun or CS abort
// BEHAVIOUR
//  Reset: all outputs 0, except spi_miso=IDLE_MISO. FSM=IDLE, shift reg=0, bit counter=0.
//  Edge detect: uses the last two synced SCLK samples. rise = 0->1, fall = 1->0.
//    cs_act = synced spi_cs_n low.
//  FSM:
//   IDLE : on rd_start && cs_act: latch rd_addr_in -> FETCH. rd_start while !cs_act is ignored.
//   FETCH: reg_rd_en=1 for exactly this cycle -> WAIT.
//   WAIT : count RD_LATENCY cycles. At the end, capture reg_rd_data -> LOAD.
//   LOAD : shreg<=data, spi_miso<=data[DATA_W-1], miso_oe<=1, bitcnt<=0 -> SHIFT.
//   SHIFT: on rise: bitcnt++. On fall with bitcnt!=0: shreg<<=1, MISO<=next MSB.
//          Rise making bitcnt==DATA_W -> DONE. Rise and fall never occur in the same cycle.
//   DONE : tx_done=1 for one cycle. MISO<=IDLE_MISO. miso_oe stays 1 while cs_act -> IDLE.
//  Latency: rd_start at cycle N -> reg_rd_en at N+1 -> MISO bit31 valid at N+2+RD_LATENCY.
//  Underrun: a rise seen in FETCH/WAIT means the master sampled before data was ready.
//   Pulse tx_err, drive IDLE_MISO for the rest of the frame, go to IDLE.
//   No register data is driven for that frame.
//  CS abort: cs_act drops in FETCH/WAIT/LOAD/SHIFT -> pulse tx_err, go to IDLE next cycle.
//   miso_oe=0, MISO=IDLE_MISO, shreg/bitcnt are cleared.
//   CS drop in DONE or IDLE is a normal end: no error.
//  miso_oe drops in the cycle after cs_act deasserts, in every state.
//  rd_start while tx_busy is ignored: no reg_rd_en, address not relatched.
//  Reset assertion at any point returns immediately to the reset values above.
//   No tx_done/tx_err pulse on reset.
//  Rises beyond DATA_W within the same CS window are ignored. MISO holds IDLE_MISO.
// TESTING
//  1 Read 0xA5C3_0F01 with RD_LATENCY=1, SCLK=10 MHz, CS low
//    -> master captures 0xA5C3_0F01, one tx_done, reg_rd_en exactly one pulse, tx_err=0.
//  2 Sweep RD_LATENCY=1..4, data 0x8000_0001
//    -> MISO bit31 valid exactly 2+RD_LATENCY cycles after rd_start, MSB and LSB correct.
//  3 SCLK rise 2 cycles after rd_start
//    -> tx_err pulse, MISO=IDLE_MISO for the whole frame, no tx_done.
//  4 CS high after 13 bits of 0xFFFF_FFFF
//    -> tx_err pulse, miso_oe=0 next cycle, FSM IDLE. The next read of 0x1234_5678 is clean.
//  5 Second rd_start during SHIFT with a different address
//    -> ignored: reg_rd_addr unchanged, the frame completes with the original data.
//  6 rst_n_syn low mid-SHIFT, then released and a new read issued
//    -> outputs at reset values asynchronously, no pulses, the following read is correct.

Source files
------------

// File: rtl/spi_miso_tx_4mb.sv
// Read-back side of the 4MB SPI register interface: fetches one register word
// and shifts it out MSB-first on MISO (mode 0), oversampling SCLK/CS_N in clk_100m.
module spi_miso_tx_4mb #(
  parameter int   DATA_W      = 32,
  parameter int   RD_LATENCY  = 1,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic              clk_100m,
  input  logic              rst_n_syn,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              rd_start,
  input  logic [15:0]       rd_addr_in,
  output logic              reg_rd_en,
  output logic [15:0]       reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              spi_miso,
  output logic              miso_oe,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SHIFT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic [DATA_W-1:0]      r_shreg;
  logic [CNT_W-1:0]       r_bitcnt;
  logic [LAT_W-1:0]       r_lat_cnt;
  logic [15:0]            r_addr;
  logic                   r_miso;
  logic                   r_oe;

  logic w_sclk, w_sclk_rise, w_sclk_fall, w_cs_act;
  logic w_abort, w_underrun, w_lat_last, w_last_bit;

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_act    = ~r_cs_sync[SYNC_STAGES-1];
  assign w_lat_last  = (r_lat_cnt == LAT_W'(RD_LATENCY - 1));
  assign w_last_bit  = (r_bitcnt == CNT_W'(DATA_W - 1));
  assign w_underrun  = w_sclk_rise && ((r_state == S_FETCH) || (r_state == S_WAIT));
  assign w_abort     = !w_cs_act && ((r_state == S_FETCH) || (r_state == S_WAIT) ||
                                     (r_state == S_LOAD)  || (r_state == S_SHIFT));

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (rd_start && w_cs_act) w_next = S_FETCH;
      S_FETCH: w_next = (w_abort || w_underrun) ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (w_abort || w_underrun) w_next = S_IDLE;
        else if (w_lat_last)       w_next = S_LOAD;
      end
      S_LOAD:  w_next = w_abort ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (w_abort)                        w_next = S_IDLE;
        else if (w_sclk_rise && w_last_bit) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    reg_rd_en = (r_state == S_FETCH);
    tx_busy   = (r_state != S_IDLE);
    tx_done   = (r_state == S_DONE);
    tx_err    = w_abort || w_underrun;
  end

  // The word is loaded on the edge leaving WAIT so bit31 is on MISO while in LOAD.
  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_lat_cnt <= '0;
      r_addr    <= '0;
      r_miso    <= IDLE_MISO;
      r_oe      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && rd_start && w_cs_act) r_addr <= rd_addr_in;
      case (r_state)
        S_FETCH: r_lat_cnt <= '0;
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          if (!w_abort && !w_underrun && w_lat_last) begin
            r_shreg  <= reg_rd_data;
            r_miso   <= reg_rd_data[DATA_W-1];
            r_oe     <= 1'b1;
            r_bitcnt <= '0;
          end
        end
        S_LOAD, S_SHIFT: begin
          if (w_sclk_rise) begin
            r_bitcnt <= r_bitcnt + CNT_W'(1);
          end else if (w_sclk_fall && (r_bitcnt != '0)) begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            r_miso  <= r_shreg[DATA_W-2];
          end
        end
        S_DONE:  r_miso <= IDLE_MISO;
        default: ;
      endcase
      if (w_abort) begin
        r_shreg  <= '0;
        r_bitcnt <= '0;
        r_miso   <= IDLE_MISO;
      end
      if (!w_cs_act) r_oe <= 1'b0;
    end
  end

  assign reg_rd_addr = r_addr;
  assign spi_miso    = r_miso;
  assign miso_oe     = r_oe;

endmodule

// File: tb/tb_spi_miso_tx_4mb.sv
// Randomized bench for spi_miso_tx_4mb: four instances (RD_LATENCY 1..4) share one
// SPI master; a register-block model and frame-level expectations judge each one.
`timescale 1ns/1ps
module tb_spi_miso_tx_4mb;
  localparam int   NI        = 4;
  localparam logic IDLE_MISO = 1'b0;

  logic        clk100m  = 1'b0;
  logic        rstNSyn  = 1'b0;
  logic        spiSclk  = 1'b0;
  logic        spiCsN   = 1'b1;
  logic        rdStart  = 1'b0;
  logic [15:0] rdAddrIn = '0;

  logic [NI-1:0] regRdEn, spiMiso, misoOe, txBusy, txDone, txErr;
  logic [15:0]   regRdAddr [NI];
  logic [31:0]   mem [logic [15:0]];

  int nTests = 0;
  int nFail  = 0;

  int            cyc = 0, startCyc = -1, frameId = 0, seenFrame = 0;
  int            enCnt [NI], doneCnt [NI], errCnt [NI], oeCyc [NI];
  logic [15:0]   addrAtEn [NI];
  logic [NI-1:0] misoAtOe = '0, errFollowBad = '0, misoHigh = '0, errPend = '0, oePrev = '0;

  always #5 clk100m = ~clk100m;

  for (genvar g = 0; g < NI; g++) begin : gInst
    logic [31:0] rdData = '0;
    int          pend   = 0;

    spi_miso_tx_4mb #(
      .DATA_W(32), .RD_LATENCY(g + 1), .SYNC_STAGES(2), .IDLE_MISO(IDLE_MISO)
    ) uDut (
      .clk_100m(clk100m), .rst_n_syn(rstNSyn), .spi_sclk(spiSclk), .spi_cs_n(spiCsN),
      .rd_start(rdStart), .rd_addr_in(rdAddrIn), .reg_rd_en(regRdEn[g]),
      .reg_rd_addr(regRdAddr[g]), .reg_rd_data(rdData), .spi_miso(spiMiso[g]),
      .miso_oe(misoOe[g]), .tx_busy(txBusy[g]), .tx_done(txDone[g]), .tx_err(txErr[g])
    );

    // Register block: valid data only in the cycle g+1 cycles after the strobe, noise otherwise.
    always @(negedge clk100m) begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) rdData = mem.exists(regRdAddr[g]) ? mem[regRdAddr[g]] : 32'hDEAD_BEEF;
        else           rdData = $urandom;
      end else begin
        rdData = $urandom;
      end
      if (regRdEn[g]) pend = g + 1;
    end
  end

  // Frame monitor: counts strobes/pulses and records when MISO first becomes valid.
  always begin
    @(posedge clk100m);
    #2;
    cyc++;
    if (frameId != seenFrame) begin
      seenFrame = frameId;
      startCyc  = -1;
      misoHigh  = '0;
      errFollowBad = '0;
      for (int i = 0; i < NI; i++) begin
        enCnt[i] = 0; doneCnt[i] = 0; errCnt[i] = 0; oeCyc[i] = -1; addrAtEn[i] = '0;
      end
    end
    if (rdStart && !spiCsN && startCyc < 0) startCyc = cyc;
    for (int i = 0; i < NI; i++) begin
      if (regRdEn[i]) begin enCnt[i]++; addrAtEn[i] = regRdAddr[i]; end
      if (txDone[i]) doneCnt[i]++;
      if (errPend[i]) begin
        errPend[i] = 1'b0;
        if (misoOe[i] || txBusy[i] || (spiMiso[i] !== IDLE_MISO)) errFollowBad[i] = 1'b1;
      end
      if (txErr[i]) begin errCnt[i]++; errPend[i] = 1'b1; end
      if (misoOe[i] && !oePrev[i]) begin oeCyc[i] = cyc; misoAtOe[i] = spiMiso[i]; end
      oePrev[i] = misoOe[i];
      if (spiMiso[i] !== IDLE_MISO) misoHigh[i] = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic string tagOf(input string tag, input int i);
    return $sformatf("%s L%0d", tag, i + 1);
  endfunction

  // mode: 0 normal, 1 early SCLK (underrun), 2 CS abort after 13 bits,
  // 3 second rd_start mid-shift, 4 reset mid-shift, 5 extra SCLK rises past 32.
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data,
                               input int mode, input int half);
    logic [31:0]   capWord [NI];
    logic [NI-1:0] extraHigh;
    logic [15:0]   addr2;
    int            nBits;
    bit            cut;
    cut       = 1'b0;
    extraHigh = '0;
    for (int i = 0; i < NI; i++) capWord[i] = '0;
    nBits = (mode == 5) ? 35 : 32;
    addr2 = addr ^ 16'h0100;
    mem[addr]  = data;
    mem[addr2] = ~data;
    frameId++;
    @(negedge clk100m);
    spiCsN = 1'b0;
    repeat (4) @(negedge clk100m);
    rdAddrIn = addr;
    rdStart  = 1'b1;
    if (mode == 1) spiSclk = 1'b1;
    @(negedge clk100m);
    rdStart  = 1'b0;
    rdAddrIn = 16'($urandom);
    if (mode != 1) repeat (10) @(negedge clk100m);
    for (int b = 0; b < nBits && !cut; b++) begin
      for (int i = 0; i < NI; i++) begin
        if (b < 32) capWord[i] = {capWord[i][30:0], spiMiso[i]};
        else if (spiMiso[i] !== IDLE_MISO) extraHigh[i] = 1'b1;
      end
      spiSclk = 1'b1;
      repeat (half) @(negedge clk100m);
      if (mode == 4 && b == 10) begin
        @(negedge clk100m);
        #2 rstNSyn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
          checkOutput(tagOf("reset_async", i),
                      32'({regRdEn[i], spiMiso[i] ^ IDLE_MISO, misoOe[i], txBusy[i], txDone[i], txErr[i]}), 32'd0);
        @(negedge clk100m);
        spiSclk = 1'b0;
        spiCsN  = 1'b1;
        repeat (4) @(negedge clk100m);
        rstNSyn = 1'b1;
        cut = 1'b1;
      end else begin
        spiSclk = 1'b0;
        repeat (half) @(negedge clk100m);
        if (mode == 3 && b == 8) begin
          rdAddrIn = addr2;
          rdStart  = 1'b1;
          @(negedge clk100m);
          rdStart  = 1'b0;
        end
        if (mode == 2 && b == 12) cut = 1'b1;
      end
    end
    if (mode == 0 || mode == 3 || mode == 5) begin
      repeat (6) @(negedge clk100m);
      for (int i = 0; i < NI; i++) begin
        checkOutput(tagOf("oe_hold", i), 32'(misoOe[i]), 32'd1);
        checkOutput(tagOf("miso_idle_after_done", i), 32'(spiMiso[i]), 32'(IDLE_MISO));
      end
    end
    spiCsN = 1'b1;
    repeat (6) @(negedge clk100m);
    for (int i = 0; i < NI; i++) begin
      checkOutput(tagOf("oe_off", i), 32'(misoOe[i]), 32'd0);
      checkOutput(tagOf("busy_off", i), 32'(txBusy[i]), 32'd0);
      case (mode)
        0, 3, 5: begin
          checkOutput(tagOf("capture", i), capWord[i], data);
          checkOutput(tagOf("done_cnt", i), 32'(doneCnt[i]), 32'd1);
          checkOutput(tagOf("err_cnt", i), 32'(errCnt[i]), 32'd0);
          checkOutput(tagOf("rd_en_cnt", i), 32'(enCnt[i]), 32'd1);
          checkOutput(tagOf("rd_addr", i), 32'(addrAtEn[i]), 32'(addr));
          checkOutput(tagOf("latency", i), 32'(oeCyc[i] - startCyc), 32'(i + 2));
          checkOutput(tagOf("first_bit", i), 32'(misoAtOe[i]), 32'(data[31]));
          if (mode == 3) checkOutput(tagOf("addr_kept", i), 32'(regRdAddr[i]), 32'(addr));
          if (mode == 5) checkOutput(tagOf("extra_rise_idle", i), 32'(extraHigh[i]), 32'd0);
        end
        1: begin
          checkOutput(tagOf("underrun_err", i), 32'(errCnt[i]), 32'd1);
          checkOutput(tagOf("underrun_done", i), 32'(doneCnt[i]), 32'd0);
          checkOutput(tagOf("underrun_capture", i), capWord[i], 32'd0);
          checkOutput(tagOf("underrun_miso", i), 32'(misoHigh[i]), 32'd0);
          checkOutput(tagOf("err_follow", i), 32'(errFollowBad[i]), 32'd0);
        end
        2: begin
          checkOutput(tagOf("abort_err", i), 32'(errCnt[i]), 32'd1);
          checkOutput(tagOf("abort_done", i), 32'(doneCnt[i]), 32'd0);
          checkOutput(tagOf("abort_capture", i), capWord[i], 32'h0000_1FFF);
          checkOutput(tagOf("err_follow", i), 32'(errFollowBad[i]), 32'd0);
        end
        default: begin
          checkOutput(tagOf("reset_done", i), 32'(doneCnt[i]), 32'd0);
          checkOutput(tagOf("reset_err", i), 32'(errCnt[i]), 32'd0);
        end
      endcase
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk100m);
    for (int i = 0; i < NI; i++) begin
      checkOutput(tagOf("reset_state", i),
                  32'({regRdEn[i], spiMiso[i] ^ IDLE_MISO, misoOe[i], txBusy[i], txDone[i], txErr[i]}), 32'd0);
      checkOutput(tagOf("reset_addr", i), 32'(regRdAddr[i]), 32'd0);
    end
    rstNSyn = 1'b1;
    repeat (3) @(negedge clk100m);

    frameId++;
    repeat (2) @(negedge clk100m);
    rdAddrIn = 16'h0077;
    rdStart  = 1'b1;
    @(negedge clk100m);
    rdStart  = 1'b0;
    repeat (8) @(negedge clk100m);
    for (int i = 0; i < NI; i++) begin
      checkOutput(tagOf("no_cs_rd_en", i), 32'(enCnt[i]), 32'd0);
      checkOutput(tagOf("no_cs_busy", i), 32'(txBusy[i]), 32'd0);
    end

    applyStimulus(16'h0010, 32'hA5C3_0F01, 0, 5);
    applyStimulus(16'h0020, 32'h8000_0001, 0, 5);
    applyStimulus(16'h0028, $urandom | 32'h1, 1, 5);
    applyStimulus(16'h0030, 32'hFFFF_FFFF, 2, 5);
    applyStimulus(16'h0031, 32'h1234_5678, 0, 5);
    applyStimulus(16'h0040, $urandom, 3, 5);
    applyStimulus(16'h0050, $urandom, 4, 5);
    applyStimulus(16'h0051, $urandom, 0, 5);
    applyStimulus(16'h0060, $urandom, 5, 4);
    for (int k = 0; k < 6; k++)
      applyStimulus(16'($urandom), $urandom, 0, int'($urandom_range(4, 7)));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
